// File: rtl/sample_buffer_pkg.sv
// Shared constants and types for the sample buffer reader slice.
package sample_buffer_pkg;

  localparam int DEPTH  = 10000;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] sample_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  function automatic logic in_range(input addr_t a);
    return a < addr_t'(DEPTH);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port block RAM: one write port, one synchronous read-first read port.
module sample_ram
  import sample_buffer_pkg::*;
(
  input  logic    clk,
  input  logic    wr_en,
  input  addr_t   wr_addr,
  input  sample_t wr_data,
  input  addr_t   rd_addr,
  output sample_t rd_q
);

  // NOTE: storage has no reset so it maps onto block RAM; callers must mask
  // rd_q until a read has actually been issued.
  sample_t mem [DEPTH];

  // NOTE: non-blocking read and write of the same word in one edge gives the
  // old contents (read-first); a blocking write here would break that.
  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr))
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    if (in_range(rd_addr))
      rd_q <= mem[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/sample_buffer_reader.sv
// Two-stage reader of the sample buffer with range check and frame-start detect.
// Optional sequence checker enabled by defining SEQ_CHECK_EN.
module sample_buffer_reader
  import sample_buffer_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  addr_t   rd_addr,
  input  logic    wr_en,
  input  addr_t   wr_addr,
  input  sample_t wr_data,
  output sample_t rd_data,
  output logic    rd_valid,
  output logic    frame_start,
  output logic    addr_err
`ifdef SEQ_CHECK_EN
  ,
  output logic    seq_err
`endif
);

  sample_t ram_q;
  addr_t   prev_addr;
  logic    s1_valid;
  logic    s1_err;
  logic    s1_frame;
  logic    rd_oor;
  logic    frame_hit;

  sample_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_q    (ram_q)
  );

  // NOTE: every comb output gets a default first, so no latch can be inferred.
  always_comb begin
    rd_oor    = 1'b0;
    frame_hit = 1'b0;
    rd_oor    = !in_range(rd_addr);
    frame_hit = (rd_addr == '0) && (prev_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_err      <= 1'b0;
      s1_frame    <= 1'b0;
      prev_addr   <= LAST_ADDR;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      frame_start <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      s1_valid    <= 1'b1;
      s1_err      <= rd_oor;
      s1_frame    <= frame_hit;
      prev_addr   <= rd_addr;
      // Out-of-range reads leave ram_q stale, so force zero here.
      rd_data     <= (s1_valid && !s1_err) ? ram_q : '0;
      rd_valid    <= s1_valid;
      frame_start <= s1_valid && s1_frame;
      addr_err    <= s1_valid && s1_err;
    end
  end

`ifdef SEQ_CHECK_EN
  addr_t expected_addr;
  logic  primed;
  logic  seq_hit;
  logic  s1_seq;

  // An out-of-range predecessor is treated as LAST_ADDR, so 0 is expected next.
  always_comb begin
    expected_addr = '0;
    seq_hit       = 1'b0;
    if (prev_addr < LAST_ADDR)
      expected_addr = prev_addr + addr_t'(1);
    seq_hit = rd_oor || (primed && (rd_addr != expected_addr));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      primed  <= 1'b0;
      s1_seq  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      primed  <= 1'b1;
      s1_seq  <= seq_hit;
      seq_err <= s1_valid && s1_seq;
    end
  end
`endif

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Scoreboard bench for sample_buffer_reader; honours SEQ_CHECK_EN when defined.
module tb_sample_buffer_reader;

  localparam int DEPTH = 10000;

  typedef struct {
    int          stamp;
    logic        valid;
    logic [15:0] data;
    logic        frame;
    logic        err;
    logic        seq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        frame_start;
  logic        addr_err;
  logic        seq_v;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t        sb[$];
  logic [15:0] model_mem [DEPTH];
  logic [15:0] m_prev   = 16'(DEPTH - 1);
  logic        m_primed = 1'b0;

`ifdef SEQ_CHECK_EN
  logic seq_err;
  assign seq_v = seq_err;
`else
  assign seq_v = 1'b0;
`endif

  sample_buffer_reader dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_start (frame_start),
    .addr_err    (addr_err)
`ifdef SEQ_CHECK_EN
    ,
    .seq_err     (seq_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation that is due this cycle and compare.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if ({rd_valid, rd_data, frame_start, addr_err, seq_v} !==
          {e.valid, e.data, e.frame, e.err, e.seq}) begin
        n_fail++;
        $display("FAIL sb cyc=%0d got v=%b d=%h f=%b e=%b s=%b want v=%b d=%h f=%b e=%b s=%b",
                 cyc, rd_valid, rd_data, frame_start, addr_err, seq_v,
                 e.valid, e.data, e.frame, e.err, e.seq);
      end
    end
  end

  // One clock of stimulus; the reference model pushes what the outputs must be.
  task automatic drive(input logic rst, input logic [15:0] ra, input logic we,
                       input logic [15:0] wa, input logic [15:0] wd);
    exp_t e;
    logic oor;
    logic [15:0] nxt;
    @(negedge clk);
    reset = rst; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
    if (rst) begin
      while (sb.size() > 0 && sb[$].stamp > cyc) void'(sb.pop_back());
      e = '{stamp: cyc + 1, valid: 1'b0, data: 16'h0, frame: 1'b0, err: 1'b0, seq: 1'b0};
      sb.push_back(e);
      e.stamp = cyc + 2;
      sb.push_back(e);
      m_prev   = 16'(DEPTH - 1);
      m_primed = 1'b0;
    end else begin
      oor     = ra >= 16'(DEPTH);
      nxt     = (m_prev >= 16'(DEPTH - 1)) ? 16'h0 : m_prev + 16'h1;
      e.stamp = cyc + 2;
      e.valid = 1'b1;
      e.data  = oor ? 16'h0 : model_mem[ra];
      e.frame = (ra == 16'h0) && (m_prev != 16'h0);
      e.err   = oor;
`ifdef SEQ_CHECK_EN
      e.seq   = oor || (m_primed && ra != nxt);
`else
      e.seq   = 1'b0;
`endif
      sb.push_back(e);
      m_prev   = ra;
      m_primed = 1'b1;
    end
    if (we && wa < 16'(DEPTH)) model_mem[wa] = wd;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'h0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 16'h0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({rd_valid, rd_data, frame_start, addr_err} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h f=%b e=%b want all zero",
               rd_valid, rd_data, frame_start, addr_err);
    end
  endtask

  // Fill the buffer while held in reset, then stream addresses from 0.
  task automatic test_stream();
    for (int a = 0; a < DEPTH; a++)
      drive(1'b1, 16'h0, 1'b1, 16'(a), 16'(a) ^ 16'hA5A5);
    for (int a = 0; a < 200; a++)
      drive(1'b0, 16'(a), 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_wrap();
    drive(1'b0, 16'd9998, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd9999, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd0,    1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd1,    1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_collision();
    drive(1'b0, 16'd2, 1'b1, 16'd5, 16'h1111);
    drive(1'b0, 16'd5, 1'b1, 16'd5, 16'h2222);
    drive(1'b0, 16'd5, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd6, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_out_of_range();
    drive(1'b0, 16'd10000, 1'b0, 16'h0,    16'h0);
    drive(1'b0, 16'hFFFF,  1'b0, 16'h0,    16'h0);
    drive(1'b0, 16'd0,     1'b1, 16'd12000, 16'hBEEF);
    drive(1'b0, 16'd12000, 1'b0, 16'h0,    16'h0);
    drive(1'b0, 16'd7,     1'b0, 16'h0,    16'h0);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 16'd100, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd101, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 16'd102, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd103, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd0,   1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd0,   1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd1,   1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_seq();
    drive(1'b0, 16'd10,   1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd11,   1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd13,   1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd14,   1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd9999, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd0,    1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_drain();
    int overdue;
    drive(1'b0, 16'd1, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'd2, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #2;
    overdue = 0;
    foreach (sb[i]) if (sb[i].stamp <= cyc) overdue++;
    n_checks++;
    if (overdue != 0) begin
      n_fail++;
      $display("FAIL drain got %0d overdue expectations want 0", overdue);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    test_seq();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
